// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the LED matrix scan path.
package led_pkg;

  typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;

  localparam int MAX_N = 8;

  // Counter width needed to hold values 0..v-1, never narrower than one bit.
  function automatic int clog2_w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/led_array_driver.sv
// Column/row pin driver: lights column x with the cell states of that column when ena is high.
// Rows are active-low, columns one-hot; everything is dark while ena is low or x is out of range.
module led_array_driver #(
  parameter int N = 8
) (
  input  logic                 ena,
  input  logic [$clog2(N):0]   x,
  input  logic [N*N-1:0]       cells,
  output logic [N-1:0]         rows,
  output logic [N-1:0]         cols
);

  localparam int XW = $clog2(N) + 1;

  always_comb begin
    cols = '0;
    rows = '1;
    for (int j = 0; j < N; j++) begin
      if (ena && (x == XW'(j))) begin
        cols[j] = 1'b1;
        for (int i = 0; i < N; i++) begin
          rows[i] = ~cells[N*i + j];
        end
      end
    end
  end

endmodule

// File: rtl/led_scan_controller.sv
// Refresh sequencer for the LED matrix: blanks, then lights each column in turn, and swaps in a
// new frame only at the frame boundary so the display never tears.
module led_scan_controller
  import led_pkg::*;
#(
  parameter int N           = 8,
  parameter int DWELL_TICKS = 1000,
  parameter int BLANK_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [N*N-1:0]       cells_in,
  input  logic                 cells_valid,
  output logic                 cells_ready,
  output logic                 frame_start,
  output logic [$clog2(N):0]   x,
  output logic                 ena,
  output logic [N-1:0]         rows,
  output logic [N-1:0]         cols
);

  localparam int XW = $clog2(N) + 1;
  localparam int TMAX = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int TW = clog2_w(TMAX + 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_TICKS - 1);
  localparam logic [XW-1:0] COL_LAST   = XW'(N - 1);

  initial begin
    if (!(N == 3 || N == 5 || N == 8) || N > MAX_N)
      $error("led_scan_controller: N=%0d not supported", N);
    if (DWELL_TICKS < 1)
      $error("led_scan_controller: DWELL_TICKS=%0d must be >= 1", DWELL_TICKS);
    if (BLANK_TICKS < 1)
      $error("led_scan_controller: BLANK_TICKS=%0d must be >= 1", BLANK_TICKS);
  end

  scan_state_t     state, state_nxt;
  logic [XW-1:0]   col, col_nxt;
  logic [TW-1:0]   tick_cnt, tick_nxt;
  logic [N*N-1:0]  frame_q;
  logic            boundary;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    tick_nxt  = tick_cnt + TW'(1);
    if (!run) begin
      state_nxt = S_BLANK;
      col_nxt   = '0;
      tick_nxt  = '0;
    end else if (state == S_BLANK) begin
      if (tick_cnt == BLANK_LAST) begin
        state_nxt = S_DRIVE;
        tick_nxt  = '0;
      end
    end else begin
      if (tick_cnt == DWELL_LAST) begin
        state_nxt = S_BLANK;
        tick_nxt  = '0;
        col_nxt   = (col == COL_LAST) ? '0 : col + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_BLANK;
      col      <= '0;
      tick_cnt <= '0;
      frame_q  <= '0;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      tick_cnt <= tick_nxt;
      if (cells_valid && boundary)
        frame_q <= cells_in;
    end
  end

  // Gated by rst_n so no accept or frame pulse is advertised while held in reset.
  assign boundary    = rst_n && run && (state == S_BLANK) && (col == '0) && (tick_cnt == '0);
  assign cells_ready = boundary;
  assign frame_start = boundary;
  assign ena         = (state == S_DRIVE);
  assign x           = col;

  led_array_driver #(.N(N)) u_drv (
    .ena   (ena),
    .x     (x),
    .cells (frame_q),
    .rows  (rows),
    .cols  (cols)
  );

endmodule
